// File: rtl/univ_shift_reg_pkg.sv
// shift_pkg: shared definitions for univ_shift_reg.
//   mode_t / MODE_* : operation-select encodings (110/111 are reserved and mean hold)
//   state_t         : two-state burst FSM (IDLE, SHIFT)
package shift_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_LOAD = 3'd1;
  localparam mode_t MODE_SHL  = 3'd2;
  localparam mode_t MODE_SHR  = 3'd3;
  localparam mode_t MODE_ROL  = 3'd4;
  localparam mode_t MODE_ROR  = 3'd5;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control/data bundle for univ_shift_reg.
//   master : the user side, drives en/mode/pi/sin_l/sin_r/start and observes the outputs
//   slave  : the register side, the reverse
//   parity exists only when UNIV_SHIFT_REG_PARITY_EN is defined.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
  import shift_pkg::*;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] pi;
  logic             sin_l;
  logic             sin_r;
  logic             start;
  logic [WIDTH-1:0] po;
  logic             sout_lsb;
  logic             sout_msb;
  logic             busy;
  logic             done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic             parity;

  modport master (output en, mode, pi, sin_l, sin_r, start,
                  input  po, sout_lsb, sout_msb, busy, done, parity);
  modport slave  (input  en, mode, pi, sin_l, sin_r, start,
                  output po, sout_lsb, sout_msb, busy, done, parity);
`else
  modport master (output en, mode, pi, sin_l, sin_r, start,
                  input  po, sout_lsb, sout_msb, busy, done);
  modport slave  (input  en, mode, pi, sin_l, sin_r, start,
                  output po, sout_lsb, sout_msb, busy, done);
`endif

endinterface

// File: rtl/univ_shift_reg_next_val.sv
// shift_next_val: combinational next-value function of the universal register.
//   mode  : operation select (shift_pkg MODE_*); reserved codes hold
//   po    : current register contents
//   pi    : parallel load data
//   sin_l : bit entering the MSB on a right shift
//   sin_r : bit entering the LSB on a left shift
//   nxt   : value the register takes on the next enabled edge
module shift_next_val
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] po,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = po;
    case (mode)
      MODE_LOAD: nxt = pi;
      MODE_SHL:  nxt = {po[WIDTH-2:0], sin_r};
      MODE_SHR:  nxt = {sin_l, po[WIDTH-1:1]};
      MODE_ROL:  nxt = {po[WIDTH-2:0], po[WIDTH-1]};
      MODE_ROR:  nxt = {po[0], po[WIDTH-1:1]};
      default:   nxt = po;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal register (hold/load/shift/rotate) with an
// auto-serialise burst: start loads pi, then WIDTH right shifts emit the word
// LSB-first on sout_lsb while busy is high; done pulses on the first IDLE cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset (overrides en)
//   bus      : univ_shift_reg_if.slave (en, mode, pi, sin_l, sin_r, start in;
//              po, sout_lsb, sout_msb, busy, done out)
// Optional: define UNIV_SHIFT_REG_PARITY_EN to add bus.parity == ^po (registered).
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic             clk,
  input logic             rst,
  univ_shift_reg_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] po_q, po_d, nxt;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  mode_t            eff_mode;

  // One next-value function serves both paths: a burst forces SHR, and the
  // start-triggered load is just MODE_LOAD taking priority over the user mode.
  always_comb begin
    eff_mode = bus.mode;
    if (state_q == SHIFT)  eff_mode = MODE_SHR;
    else if (bus.start)    eff_mode = MODE_LOAD;
  end

  shift_next_val #(.WIDTH(WIDTH)) u_next (
    .mode  (eff_mode),
    .po    (po_q),
    .pi    (bus.pi),
    .sin_l (bus.sin_l),
    .sin_r (bus.sin_r),
    .nxt   (nxt)
  );

  always_comb begin
    po_d    = po_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (bus.en) begin
      po_d   = nxt;
      done_d = 1'b0;
      if (state_q == IDLE) begin
        if (bus.start) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      po_q    <= RESET_VAL;
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      po_q    <= po_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.po       = po_q;
  assign bus.sout_lsb = po_q[0];
  assign bus.sout_msb = po_q[WIDTH-1];
  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;

`ifdef UNIV_SHIFT_REG_PARITY_EN
  logic parity_q, parity_d;

  // Tracks the value po is about to take, so it is never a cycle behind.
  always_comb parity_d = ^po_d;

  always_ff @(posedge clk) begin
    if (rst) parity_q <= ^RESET_VAL;
    else     parity_q <= parity_d;
  end

  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  univ_shift_reg_if #(.WIDTH(W)) bus();

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register as an integer, burst as "edges remaining".
  int m_po   = 0;
  int m_left = 0;
  int m_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input int md, input int p,
                            input int sl, input int sr, input bit st);
    if (r) begin
      m_po = 0; m_left = 0; m_done = 0;
    end else if (e) begin
      m_done = 0;
      if (m_left > 0) begin
        m_po = m_po / 2 + sl * 8;
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (st) begin
        m_po = p;
        m_left = W;
      end else begin
        case (md)
          1: m_po = p;
          2: m_po = (m_po * 2 + sr) % 16;
          3: m_po = m_po / 2 + sl * 8;
          4: m_po = (m_po * 2) % 16 + m_po / 8;
          5: m_po = m_po / 2 + (m_po % 2) * 8;
          default: ;
        endcase
      end
    end
  endtask

  // Apply inputs, take one edge, advance the model, sample 1 time unit later.
  task automatic drive(input bit r, input bit e, input logic [2:0] md, input logic [3:0] p,
                       input bit sl, input bit sr, input bit st);
    rst = r; bus.en = e; bus.mode = md; bus.pi = p;
    bus.sin_l = sl; bus.sin_r = sr; bus.start = st;
    @(posedge clk);
    model_step(r, e, int'(md), int'(p), int'(sl), int'(sr), st);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] po, input bit busy, input bit done);
    chk({tag, " po"}, 32'(bus.po), 32'(po));
    chk({tag, " sout_lsb"}, 32'(bus.sout_lsb), 32'(po[0]));
    chk({tag, " sout_msb"}, 32'(bus.sout_msb), 32'(po[3]));
    chk({tag, " busy"}, 32'(bus.busy), 32'(busy));
    chk({tag, " done"}, 32'(bus.done), 32'(done));
`ifdef UNIV_SHIFT_REG_PARITY_EN
    chk({tag, " parity"}, 32'(bus.parity), 32'(^po));
`endif
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    logic [2:0] mode;
    logic [3:0] pi;
    bit         sl;
    bit         sr;
    bit         st;
    logic [3:0] po;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit e, input logic [2:0] md, input logic [3:0] p,
                     input bit sl, input bit sr, input bit st,
                     input logic [3:0] po, input bit busy, input bit done);
    vec_t v;
    v.rst = r; v.en = e; v.mode = md; v.pi = p; v.sl = sl; v.sr = sr; v.st = st;
    v.po = po; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endtask

  // Burst of word p starting now (possibly in a done cycle); start/load are
  // held high throughout SHIFT to show they are ignored.
  task automatic burst_seq(input logic [3:0] p, input string tag);
    logic [3:0] pw;
    int bcnt;
    pw = p;
    bcnt = 0;
    drive(0, 1, 3'd2, pw, 0, 0, 1);
    for (int k = 0; k < W; k++) begin
      chk($sformatf("%s bit%0d", tag, k), 32'(bus.sout_lsb), 32'(pw[k]));
      if (bus.busy) bcnt++;
      drive(0, 1, 3'd1, ~pw, 0, 0, 1);
    end
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(W));
    chk_outputs({tag, " end"}, 4'b0000, 0, 1);
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.mode = 3'd0; bus.pi = '0;
    bus.sin_l = 1'b0; bus.sin_r = 1'b0; bus.start = 1'b0;

    //  rst en mode   pi       sl sr st   po       busy done
    add(1, 1, 3'd0, 4'b0000, 0, 0, 0,  4'b0000, 0, 0);  // reset
    add(0, 1, 3'd1, 4'b1011, 0, 0, 0,  4'b1011, 0, 0);  // load
    add(0, 1, 3'd0, 4'b0000, 0, 0, 0,  4'b1011, 0, 0);  // hold
    add(0, 1, 3'd2, 4'b0000, 0, 0, 0,  4'b0110, 0, 0);  // shl, sin_r=0
    add(0, 1, 3'd3, 4'b0000, 1, 0, 0,  4'b1011, 0, 0);  // shr, sin_l=1
    add(0, 1, 3'd4, 4'b0000, 0, 0, 0,  4'b0111, 0, 0);  // rol
    add(0, 1, 3'd5, 4'b0000, 0, 0, 0,  4'b1011, 0, 0);  // ror
    add(0, 1, 3'd2, 4'b1101, 0, 1, 1,  4'b1101, 1, 0);  // start beats shl
    add(0, 1, 3'd1, 4'b1111, 0, 0, 1,  4'b0110, 1, 0);  // load/start ignored in SHIFT
    add(0, 1, 3'd0, 4'b0000, 0, 0, 0,  4'b0011, 1, 0);
    add(0, 0, 3'd1, 4'b1111, 1, 1, 1,  4'b0011, 1, 0);  // stall
    add(0, 0, 3'd1, 4'b1111, 1, 1, 1,  4'b0011, 1, 0);
    add(0, 0, 3'd1, 4'b1111, 1, 1, 1,  4'b0011, 1, 0);
    add(0, 1, 3'd0, 4'b0000, 0, 0, 0,  4'b0001, 1, 0);
    add(0, 1, 3'd0, 4'b0000, 0, 0, 0,  4'b0000, 0, 1);  // burst complete
    add(0, 0, 3'd0, 4'b0000, 0, 0, 0,  4'b0000, 0, 1);  // done holds when stalled
    add(0, 1, 3'd0, 4'b1010, 1, 0, 1,  4'b1010, 1, 0);  // start in done cycle
    add(0, 1, 3'd0, 4'b0000, 1, 0, 0,  4'b1101, 1, 0);  // 2nd SHIFT cycle
    add(1, 0, 3'd0, 4'b0000, 0, 0, 0,  4'b0000, 0, 0);  // reset mid-burst, en=0
    add(0, 1, 3'd0, 4'b0000, 0, 0, 0,  4'b0000, 0, 0);  // no done pulse
    add(0, 1, 3'd1, 4'b0101, 0, 0, 0,  4'b0101, 0, 0);
    add(0, 1, 3'd6, 4'b1111, 1, 1, 0,  4'b0101, 0, 0);  // reserved holds
    add(0, 1, 3'd7, 4'b1111, 1, 1, 0,  4'b0101, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].pi, tbl[i].sl, tbl[i].sr, tbl[i].st);
      chk_outputs($sformatf("row%0d", i), tbl[i].po, tbl[i].busy, tbl[i].done);
    end

    // Back-to-back bursts with no gap.
    burst_seq(4'b1101, "burstA");
    burst_seq(4'b0110, "burstB");
    drive(0, 1, 3'd0, 4'b0000, 0, 0, 0);
    chk_outputs("after_bursts", 4'b0000, 0, 0);

    // Randomised run against the model.
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] p;
      logic [3:0] mp;
      p = 4'($urandom_range(0, 15));
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)), p,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 5) == 0);
      mp = 4'(m_po);
      chk_outputs($sformatf("rnd%0d", n), mp, m_left > 0, m_done != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the team's 4-bit parallel-in/parallel-out register.
- Generalised in width and extended to a universal register with these modes: hold, parallel load, shift left/right, rotate left/right.
- Adds an auto-serialise burst mode (load, then emit WIDTH bits LSB-first) with busy/done status.
- Used wherever a datapath needs PIPO, SIPO or PISO conversion from a single block.

Parameters:
- WIDTH, 8, register width in bits; legal range ≥ 2.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into po on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; 0 freezes all state (po, FSM, counter, done).
- mode  input  3  operation select; honoured only in IDLE.
- pi  input  WIDTH  parallel data in.
- sin_l  input  1  serial bit entering the MSB on right shifts.
- sin_r  input  1  serial bit entering the LSB on left shifts.
- start  input  1  starts an auto-serialise burst; honoured only in IDLE.
- po  output  WIDTH  register contents (registered).
- sout_lsb  output  1  equals po[0] (combinational from register).
- sout_msb  output  1  equals po[WIDTH-1] (combinational from register).
- busy  output  1  high while FSM is in SHIFT.
- done  output  1  one-cycle pulse at burst completion (registered).

Behaviour:
- Reset (rst=1 at a clk edge; overrides en):
  - po=RESET_VAL, state=IDLE, cnt=0, done=0.
  - Reset mid-burst aborts the burst, with no done pulse.
- All updates occur only on edges where en=1. With en=0, every register holds, and done holds its value.
- IDLE with start=0, mode decode:
  - 000 hold.
  - 001 load: po<=pi.
  - 010 shift left: po<={po[WIDTH-2:0],sin_r}.
  - 011 shift right: po<={sin_l,po[WIDTH-1:1]}.
  - 100 rotate left: po<={po[WIDTH-2:0],po[WIDTH-1]}.
  - 101 rotate right: po<={po[0],po[WIDTH-1:1]}.
  - 110/111: hold (reserved).
- Single-cycle latency: a mode takes effect on the edge where it is sampled.
- IDLE with start=1: start has priority over mode.
  - po<=pi, cnt<=0, state<=SHIFT.
- SHIFT state:
  - busy=1; mode and start are ignored.
  - Each enabled edge: po shifts right with sin_l entering the MSB, and cnt increments.
  - Bit k of the loaded word is on sout_lsb during the k-th SHIFT cycle (k=0..WIDTH-1).
  - On the edge where cnt==WIDTH-1: state<=IDLE, done<=1.
- SHIFT therefore lasts exactly WIDTH enabled cycles.
- done is high for exactly one enabled cycle, the first IDLE cycle after the burst, then clears. A start sampled in that same cycle is accepted, so back-to-back bursts have no gap.
- cnt is $clog2(WIDTH) bits wide and does not wrap within a burst.
- After a burst, po holds the WIDTH sin_l bits that were shifted in.

Optional Feature:
- Macro: UNIV_SHIFT_REG_PARITY_EN.
- Defined: adds output port parity (1 bit).
  - parity is a register equal to XOR-reduce of the next po value, updated on the same edge as po.
  - Reset value is XOR-reduce of RESET_VAL.
  - It therefore always equals ^po.
- Undefined: the parity port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package shift_pkg holds:
  - mode encodings: MODE_HOLD=3'd0, MODE_LOAD=3'd1, MODE_SHL=3'd2, MODE_SHR=3'd3, MODE_ROL=3'd4, MODE_ROR=3'd5.
  - FSM state type: IDLE, SHIFT.
- One sub-module, shift_next_val: purely combinational. It computes the next po from mode, po, pi, sin_l and sin_r, and is reused by the burst path with mode forced to MODE_SHR.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset then load: rst=1 for 1 cycle, then mode=001, pi=4'b1011, en=1 → po=0000 after reset, po=1011 one edge later; hold (000) keeps 1011.
- Shift and rotate:
  - From po=1011, mode=010, sin_r=0 → 0110.
  - Then mode=011, sin_l=1 → 1011.
  - Then mode=100 → 0111.
  - Then mode=101 → 1011.
- Burst:
  - Stimulus: start=1, pi=4'b1101, sin_l=0.
  - sout_lsb over the 4 busy cycles → 1,0,1,1.
  - busy high for exactly 4 cycles; done pulses once on the next cycle; po=0000.
- Enable stall: mid-burst, drop en for 3 cycles → po, cnt, busy and sout_lsb frozen; the burst resumes and completes with the correct bit order and total busy=4 enabled cycles.
- Priority and ignore rules:
  - start=1 with mode=010 in IDLE → load, not shift.
  - start or mode=001 during SHIFT → ignored.
  - start in the done cycle → new burst begins immediately.
- Reset mid-burst: rst=1 in the 2nd SHIFT cycle → po=0000, busy=0, no done pulse.
- Parity (macro defined): parity tracks ^po across all of the above.
